// File: rtl/rv32_pkg.sv
// rv32_pkg: shared memory-size encodings and LSU state type
// Contents:
//   BYTE / HALFWORD / WORD  mem_size encodings driven by the decoder
//   lsu_state_e             load/store unit FSM states
package rv32_pkg;
    localparam logic [2:0] BYTE     = 3'b000;
    localparam logic [2:0] HALFWORD = 3'b001;
    localparam logic [2:0] WORD     = 3'b010;
    typedef enum logic [1:0] {IDLE, REQ, WAIT} lsu_state_e;
endpackage

// File: rtl/lsu_align.sv
// lsu_align: byte-lane alignment for stores and load extraction/extension
// Ports:
//   size, offset   access size and byte offset within the word
//   unsign         zero-extend (1) or sign-extend (0) the load result
//   wdata          store data, lane-replicated onto wdata_lane
//   rdata          raw bus read word, extracted/extended onto rdata_ext
//   be             byte enables for the access
//   legal          size is defined and the address is naturally aligned
module lsu_align
    import rv32_pkg::*;
(
    input  logic [2:0]  size,
    input  logic [1:0]  offset,
    input  logic        unsign,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_lane,
    output logic [31:0] rdata_ext,
    output logic        legal
);
    logic [31:0] shifted;

    assign legal = (size == BYTE) || (size == HALFWORD && !offset[0]) ||
                   (size == WORD && offset == 2'b00);
    assign be = (size == BYTE)     ? 4'b0001 << offset :
                (size == HALFWORD) ? 4'b0011 << offset : 4'b1111;
    assign wdata_lane = (size == BYTE)     ? {4{wdata[7:0]}} :
                        (size == HALFWORD) ? {2{wdata[15:0]}} : wdata;
    // Move the addressed lane down to bit 0 before extending.
    assign shifted = rdata >> {offset, 3'b000};
    assign rdata_ext = (size == BYTE)     ? {{24{!unsign && shifted[7]}}, shifted[7:0]} :
                       (size == HALFWORD) ? {{16{!unsign && shifted[15]}}, shifted[15:0]} : rdata;
endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store unit controller between EX/WB and a req/gnt/rvalid bus
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   ex_valid/ex_ready                operation handshake from EX
//   mem_wren/mem_load/mem_size/mem_unsign, addr, wdata, rd_addr
//                                    operation fields from decode/EX
//   busy                             pipeline stall while not idle
//   bus_req/we/addr/be/wdata         request channel, held until bus_gnt
//   bus_gnt, bus_rvalid, bus_rdata   bus responses
//   wb_valid/wb_rd_addr/wb_data      one-cycle load writeback
//   fault                            one-cycle pulse on illegal access or timeout
// Optional: define LSU_TIMEOUT_EN to abandon a transfer after TIMEOUT_CYCLES.
module lsu_ctrl
    import rv32_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic        mem_wren,
    input  logic        mem_load,
    input  logic [2:0]  mem_size,
    input  logic        mem_unsign,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [4:0]  rd_addr,
    output logic        busy,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_gnt,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata,
    output logic        wb_valid,
    output logic [4:0]  wb_rd_addr,
    output logic [31:0] wb_data,
    output logic        fault
);
    lsu_state_e  state, state_n;
    logic [2:0]  size_q;
    logic [1:0]  off_q;
    logic        uns_q;
    logic [4:0]  rd_q;
    logic        idle, accept, legal, done, timeout_hit;
    logic [3:0]  be;
    logic [31:0] lane, ext;

    assign idle     = (state == IDLE);
    assign ex_ready = idle;
    assign busy     = !idle;
    assign accept   = ex_valid && idle && (mem_wren || mem_load);
    assign done     = (state == REQ && bus_gnt) || (state == WAIT && bus_rvalid);

    // One aligner serves both paths: live fields at accept, latched fields for the load return.
    lsu_align u_align (
        .size       (idle ? mem_size : size_q),
        .offset     (idle ? addr[1:0] : off_q),
        .unsign     (uns_q),
        .wdata      (wdata),
        .rdata      (bus_rdata),
        .be         (be),
        .wdata_lane (lane),
        .rdata_ext  (ext),
        .legal      (legal)
    );

`ifdef LSU_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= '0;
        else        cnt <= (idle || state_n != state) ? '0 : cnt + 1'b1;
    end
    // cnt counts completed cycles in the current state; this is the last permitted one.
    assign timeout_hit = !idle && !done && cnt == CW'(TIMEOUT_CYCLES - 1);
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign timeout_hit    = 1'b0;
`endif

    always_comb begin
        state_n = state;
        if (idle)             state_n = (accept && legal) ? REQ : IDLE;
        else if (timeout_hit) state_n = IDLE;
        else if (done)        state_n = (state == REQ && !bus_we) ? WAIT : IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_req    <= 1'b0;
            bus_we     <= 1'b0;
            bus_addr   <= '0;
            bus_be     <= '0;
            bus_wdata  <= '0;
            wb_valid   <= 1'b0;
            wb_rd_addr <= '0;
            wb_data    <= '0;
            fault      <= 1'b0;
            size_q     <= '0;
            off_q      <= '0;
            uns_q      <= 1'b0;
            rd_q       <= '0;
        end else begin
            bus_req  <= (state_n == REQ);
            fault    <= (accept && !legal) || timeout_hit;
            wb_valid <= (state == WAIT) && bus_rvalid;
            if (accept && legal) begin
                bus_we    <= mem_wren;
                bus_addr  <= {addr[31:2], 2'b00};
                bus_be    <= be;
                bus_wdata <= lane;
                size_q    <= mem_size;
                off_q     <= addr[1:0];
                uns_q     <= mem_unsign;
                rd_q      <= rd_addr;
            end
            if (state == WAIT && bus_rvalid) begin
                wb_data    <= ext;
                wb_rd_addr <= rd_q;
            end
        end
    end
endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: directed self-checking bench for lsu_ctrl with a transaction-level model
module tb_lsu_ctrl;
    import rv32_pkg::*;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        ex_valid = 0, mem_wren = 0, mem_load = 0, mem_unsign = 0;
    logic [2:0]  mem_size = 0;
    logic [31:0] addr = 0, wdata = 0, bus_rdata = 0;
    logic [4:0]  rd_addr = 0;
    logic        bus_gnt = 0, bus_rvalid = 0;
    logic        ex_ready, busy, bus_req, bus_we, wb_valid, fault;
    logic [31:0] bus_addr, bus_wdata, wb_data;
    logic [3:0]  bus_be;
    logic [4:0]  wb_rd_addr;

    int checks = 0, failures = 0;

    // Expected request fields and pending results of the operation in flight.
    logic        exp_we;
    logic [31:0] exp_addr, exp_wd, exp_wb;
    logic [3:0]  exp_be;
    logic [4:0]  exp_rd;
    bit          wb_pend = 0, fault_pend = 0;
    logic [31:0] last_wb, cap_addr, cap_wd;
    logic [4:0]  last_rd;
    logic [3:0]  cap_be;
    int          last_busy;

    always #5 clk = ~clk;

    lsu_ctrl dut (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_ready(ex_ready),
        .mem_wren(mem_wren), .mem_load(mem_load), .mem_size(mem_size), .mem_unsign(mem_unsign),
        .addr(addr), .wdata(wdata), .rd_addr(rd_addr), .busy(busy),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
        .bus_wdata(bus_wdata), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata),
        .wb_valid(wb_valid), .wb_rd_addr(wb_rd_addr), .wb_data(wb_data), .fault(fault)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic bit m_legal(input logic [2:0] sz, input logic [31:0] a);
        return sz <= 3'd2 && (a % (32'd1 << sz)) == 0;
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] sz, input logic [1:0] off);
        int n;
        n = 1 << sz;
        return 4'(((1 << n) - 1) << off);
    endfunction

    function automatic logic [31:0] m_lane(input logic [2:0] sz, input logic [31:0] wd);
        logic [31:0] r;
        int n;
        n = 1 << sz;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % n) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] sz, input logic [1:0] off,
                                           input bit uns, input logic [31:0] rd);
        longint v, mask;
        int n;
        n = 1 << sz;
        v = longint'(rd >> (8 * off));
        mask = (64'd1 << (8 * n)) - 1;
        v = v & mask;
        if (!uns && v[8*n-1]) v = v | ~mask;
        return v[31:0];
    endfunction

    // The single compare process: bus fields while requesting, and every wb/fault pulse.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("ready_vs_busy", ex_ready, !busy);
            if (bus_req) begin
                chk("bus_we", bus_we, exp_we);
                chk("bus_addr", bus_addr, exp_addr);
                chk("bus_be", bus_be, exp_be);
                chk("bus_wdata", bus_wdata, exp_wd);
            end
            if (wb_valid) begin
                chk("wb_expected", wb_pend, 1);
                chk("wb_data", wb_data, exp_wb);
                chk("wb_rd_addr", wb_rd_addr, exp_rd);
                last_wb = wb_data;
                last_rd = wb_rd_addr;
                wb_pend = 0;
            end
            if (fault) begin
                chk("fault_expected", fault_pend, 1);
                fault_pend = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic wr, input logic ld, input logic [2:0] sz,
                         input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd, input bit uns);
        ex_valid = 1; mem_wren = wr; mem_load = ld; mem_size = sz;
        addr = a; wdata = wd; rd_addr = rd; mem_unsign = uns;
    endtask

    task automatic do_op(input logic wr, input logic ld, input logic [2:0] sz, input logic [31:0] a,
                         input logic [31:0] wd, input logic [4:0] rd, input bit uns,
                         input int gl, input logic [31:0] rdat);
        bit legal, is_load;
        legal   = m_legal(sz, a);
        is_load = ld && !wr;
        exp_we  = wr;
        exp_addr = {a[31:2], 2'b00};
        exp_be  = legal ? m_be(sz, a[1:0]) : 4'b0;
        exp_wd  = legal ? m_lane(sz, wd) : 32'b0;
        exp_wb  = legal ? m_load(sz, a[1:0], uns, rdat) : 32'b0;
        exp_rd  = rd;
        fault_pend = !legal;
        wb_pend    = legal && is_load;
        last_busy  = 0;
        drive(wr, ld, sz, a, wd, rd, uns);
        tick();
        ex_valid = 0;
        if (!legal) begin
            chk("ill_bus_req", bus_req, 0);
            chk("ill_ready", ex_ready, 1);
            chk("ill_fault", fault, 1);
            tick();
            chk("ill_fault_pulse", fault, 0);
            chk("ill_bus_req2", bus_req, 0);
            chk("ill_fault_seen", fault_pend, 0);
            return;
        end
        chk("req_rise", bus_req, 1);
        cap_addr = bus_addr; cap_be = bus_be; cap_wd = bus_wdata;
        repeat (gl) begin
            last_busy += busy;
            tick();
        end
        // rvalid with garbage alongside gnt must be ignored.
        bus_gnt = 1; bus_rvalid = 1; bus_rdata = ~rdat;
        last_busy += busy;
        tick();
        bus_gnt = 0; bus_rvalid = 0;
        if (!is_load) begin
            chk("st_idle", busy, 0);
        end else begin
            chk("ld_wait", {bus_req, busy}, 2'b01);
            chk("ld_no_early_wb", wb_valid, 0);
            bus_rvalid = 1; bus_rdata = rdat;
            tick();
            bus_rvalid = 0;
            chk("wb_latency", wb_valid, 1);
            chk("wb_idle", busy, 0);
        end
        tick();
        chk("wb_one_cycle", wb_valid, 0);
        chk("wb_seen", wb_pend, 0);
        chk("no_stray_fault", fault_pend, 0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", ex_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_req", bus_req, 0);
        chk("rst_be", bus_be, 0);
        chk("rst_wb", wb_valid, 0);
        chk("rst_fault", fault, 0);
        rst_n = 1;
        tick();

        // Model pins against hand-computed values.
        chk("pin_m_lb", m_load(BYTE, 2'd2, 0, 32'h12FF3456), 32'hFFFFFFFF);
        chk("pin_m_lhu", m_load(HALFWORD, 2'd2, 1, 32'h80011234), 32'h00008001);
        chk("pin_m_be", m_be(BYTE, 2'd3), 4'b1000);

        do_op(1, 0, BYTE, 32'h1003, 32'h000000A5, 5'd0, 0, 2, 32'h0);
        chk("sb_addr", cap_addr, 32'h1000);
        chk("sb_be", cap_be, 4'b1000);
        chk("sb_wdata", cap_wd, 32'hA5A5A5A5);
        chk("sb_busy_cycles", last_busy, 3);

        do_op(0, 1, BYTE, 32'h2002, 32'h0, 5'd5, 0, 0, 32'h12FF3456);
        chk("lb_data", last_wb, 32'hFFFFFFFF);
        chk("lb_rd", last_rd, 5);
        do_op(0, 1, BYTE, 32'h2002, 32'h0, 5'd5, 1, 0, 32'h12FF3456);
        chk("lbu_data", last_wb, 32'h000000FF);
        do_op(0, 1, HALFWORD, 32'h2002, 32'h0, 5'd7, 0, 1, 32'h80011234);
        chk("lh_data", last_wb, 32'hFFFF8001);
        chk("lh_be", cap_be, 4'b1100);
        do_op(0, 1, HALFWORD, 32'h2002, 32'h0, 5'd7, 1, 0, 32'h80011234);
        chk("lhu_data", last_wb, 32'h00008001);
        do_op(0, 1, BYTE, 32'h2001, 32'h0, 5'd9, 0, 0, 32'h12FF7F56);
        chk("lb_pos", last_wb, 32'h0000007F);
        do_op(0, 1, WORD, 32'h3000, 32'h0, 5'd0, 0, 1, 32'hDEADBEEF);
        chk("lw_x0_data", last_wb, 32'hDEADBEEF);
        chk("lw_x0_rd", last_rd, 0);

        do_op(0, 1, WORD, 32'h3002, 32'h0, 5'd3, 0, 0, 32'h0);
        do_op(0, 1, 3'b011, 32'h3000, 32'h0, 5'd3, 0, 0, 32'h0);
        do_op(1, 0, HALFWORD, 32'h3001, 32'h1234, 5'd0, 0, 0, 32'h0);

        do_op(1, 0, HALFWORD, 32'h3002, 32'h1234ABCD, 5'd0, 0, 0, 32'h0);
        chk("sh_wdata", cap_wd, 32'hABCDABCD);
        chk("sh_be", cap_be, 4'b1100);
        do_op(1, 1, WORD, 32'h4004, 32'hCAFEF00D, 5'd4, 0, 0, 32'h11111111);
        chk("both_is_store_we", exp_we, 1);
        chk("both_is_store_wd", cap_wd, 32'hCAFEF00D);
        chk("sw_busy_cycles", last_busy, 1);

        drive(0, 0, WORD, 32'h5000, 32'h0, 5'd1, 0);
        tick();
        ex_valid = 0;
        chk("nop_busy", busy, 0);
        chk("nop_req", bus_req, 0);
        chk("nop_fault", fault, 0);

        // Reset while waiting for read data: the late rvalid must be dropped.
        exp_we = 0; exp_addr = 32'h6000; exp_be = 4'b1111; exp_wd = 32'h0; exp_rd = 5'd2;
        drive(0, 1, WORD, 32'h6000, 32'h0, 5'd2, 0);
        tick();
        ex_valid = 0; bus_gnt = 1;
        tick();
        bus_gnt = 0;
        chk("rst_wait_busy", busy, 1);
        rst_n = 0;
        #1;
        chk("rst_wait_req", bus_req, 0);
        chk("rst_wait_ready", ex_ready, 1);
        tick();
        rst_n = 1;
        tick();
        tick();
        bus_rvalid = 1; bus_rdata = 32'h55555555;
        tick();
        bus_rvalid = 0;
        chk("late_rvalid_wb", wb_valid, 0);
        chk("late_rvalid_busy", busy, 0);
        tick();

        // An ungranted store: either times out or waits until reset.
        exp_we = 1; exp_addr = 32'h7000; exp_be = 4'b1111; exp_wd = 32'h0BADC0DE;
        drive(1, 0, WORD, 32'h7000, 32'h0BADC0DE, 5'd0, 0);
        tick();
        ex_valid = 0;
`ifdef LSU_TIMEOUT_EN
        begin
            int n;
            n = 0;
            fault_pend = 1;
            while (fault !== 1'b1 && n < 400) begin
                tick();
                n++;
            end
            chk("timeout_cycles", n, 255);
            chk("timeout_req", bus_req, 0);
            chk("timeout_ready", ex_ready, 1);
            tick();
            chk("timeout_pulse", fault, 0);
        end
`else
        repeat (300) tick();
        chk("hang_busy", busy, 1);
        chk("hang_req", bus_req, 1);
        chk("hang_fault", fault, 0);
`endif
        rst_n = 0;
        #1;
        chk("rst_req_drop", bus_req, 0);
        tick();
        rst_n = 1;
        tick();
        chk("final_ready", ex_ready, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Load/store unit controller: the consumer end of the decoder's memory-control bundle (mem_wren, mem_load, mem_size, mem_unsign).
- Takes one memory operation at a time from the EX stage, using the ALU result as the address and rs2_data as store data.
- Issues a word-aligned request with byte enables on a req/gnt/rvalid data bus.
- Returns sign- or zero-extended load data to writeback, and stalls the pipeline while busy.

Parameters:
TIMEOUT_CYCLES, 255, max cycles in REQ or WAIT before the bus is declared hung (used only with LSU_TIMEOUT_EN)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
ex_valid  in  1  EX stage presents an operation
ex_ready  out  1  LSU can accept an operation
mem_wren  in  1  store
mem_load  in  1  load
mem_size  in  3  000 BYTE, 001 HALFWORD, 010 WORD; other values illegal
mem_unsign  in  1  zero-extend load
addr  in  32  effective byte address
wdata  in  32  store data (rs2_data)
rd_addr  in  5  load destination register
busy  out  1  state != IDLE; pipeline stall
bus_req  out  1  request valid
bus_we  out  1  1 = write
bus_addr  out  32  {addr[31:2],2'b00}
bus_be  out  4  byte enables
bus_wdata  out  32  lane-replicated store data
bus_gnt  in  1  request accepted
bus_rvalid  in  1  read data valid
bus_rdata  in  32  read data
wb_valid  out  1  one-cycle load-result pulse
wb_rd_addr  out  5  load destination register
wb_data  out  32  extended load data
fault  out  1  one-cycle pulse: misaligned access, illegal size, or timeout

Behaviour:
- Clock, reset and outputs
  - Single clock domain.
  - Reset is asynchronous, active-low (rst_n); outputs are registered.
  - Reset values: state IDLE, all registered outputs 0 (bus_be 4'b0000), so ex_ready = 1.
- Accept
  - ex_ready = (state == IDLE).
  - An operation is accepted when ex_valid && ex_ready && (mem_wren || mem_load).
  - If both mem_wren and mem_load are set, it is treated as a store.
  - ex_valid with neither set: no action; the LSU stays in IDLE.
- Checks at accept
  - HALFWORD requires addr[0] = 0.
  - WORD requires addr[1:0] = 0.
  - BYTE is always legal.
  - Illegal size or misalignment: no bus access, fault = 1 for the next cycle, no wb_valid, state stays IDLE.
- Lane logic (computed at accept, registered)
  - Byte: bus_be = 4'b0001 << addr[1:0]; bus_wdata = {4{wdata[7:0]}}.
  - Halfword: bus_be = 4'b0011 << addr[1:0]; bus_wdata = {2{wdata[15:0]}}.
  - Word: bus_be = 4'b1111; bus_wdata = wdata.
  - For loads, bus_be is driven identically.
  - Offset, size, unsign and rd_addr are latched at accept.
- FSM states: IDLE, REQ, WAIT.
  - IDLE -> REQ on a legal accept. bus_req rises in the cycle after accept.
  - REQ: bus_req, bus_we, bus_addr, bus_be and bus_wdata are held stable until bus_gnt.
    - On gnt with a store: clear bus_req, go to IDLE.
    - On gnt with a load: clear bus_req, go to WAIT.
  - WAIT: on bus_rvalid, extract the byte or half at the latched offset and sign- or zero-extend it (word passes through). Register into wb_data, set wb_rd_addr and wb_valid = 1 for exactly one cycle, go to IDLE.
  - bus_rvalid is ignored outside WAIT, including in the same cycle as gnt.
- Latency
  - Load with zero-wait gnt and rvalid one cycle after gnt: accept at T, bus_req at T+1, rvalid at T+2, wb_valid at T+3.
  - Store with zero-wait gnt: busy for 1 cycle.
- A new operation may be accepted in the same cycle wb_valid is high.
- rd_addr = 0 loads are still performed and written back; the register file ignores writes to x0.
- Reset mid-operation: bus_req drops immediately and the state returns to IDLE. A late bus_rvalid is then ignored, producing no wb_valid.

Optional Feature:
Macro LSU_TIMEOUT_EN.
- Defined: a counter, cleared on entering REQ or WAIT, increments each cycle in those states. Reaching TIMEOUT_CYCLES gives fault = 1 for one cycle, bus_req = 0, no wb_valid, return to IDLE.
- Undefined: no counter; the LSU waits indefinitely.

Decomposition:
- Shared package rv32_pkg:
  - mem_size constants BYTE = 3'b000, HALFWORD = 3'b001, WORD = 3'b010.
  - lsu_state_e enum {IDLE, REQ, WAIT}.
- One combinational sub-module, lsu_align: byte-enable generation, store-lane replication, and load extraction/extension. It is shared by both paths and testable standalone.

Test Plan:
- SB addr 0x1003, wdata 0x000000A5, gnt 2 cycles late -> bus_addr 0x1000, bus_be 1000, bus_wdata 0xA5A5A5A5 held stable until gnt; no wb_valid; busy for 3 cycles.
- LB / LBU at addr 0x2002, rd 5, bus_rdata 0x12FF3456 -> wb_data 0xFFFFFFFF / 0x000000FF; wb_rd_addr 5; wb_valid at T+3.
- LH / LHU at addr 0x2002, bus_rdata 0x80011234 -> wb_data 0xFFFF8001 / 0x00008001; bus_be 1100.
- LW addr 0x3002, then mem_size 3'b011 -> fault pulse each time; bus_req stays 0; ex_ready stays 1; no wb_valid.
- rst_n low while in WAIT, bus_rvalid 2 cycles after release -> bus_req 0 immediately, state IDLE, no wb_valid.
- LSU_TIMEOUT_EN defined, gnt never asserted -> fault pulse after 255 cycles in REQ; bus_req drops; ex_ready = 1.
